mure_block_packer: RTL and testbench
====================================

# mure_block_packer

Parametrised successor to the single-lane retirement serializer. It takes NRET pre-classified commit ports per cycle and closes E-trace instruction blocks (iaddr, iretire, ilastsize, itype, cause, tval, priv). Blocks are buffered in a multi-push/multi-pop circular store and presented on N output lanes to the trace encoder under a ready/valid handshake. Up to NRET blocks can close per cycle and up to N can drain per cycle; buffer overflow is detected.

## Interface
- NRET, 2, commit ports per cycle, ≥1
- N, 2, output lanes, ≥1
- FIFO_DEPTH, 16, block store entries, power of two, ≥ max(NRET,N)
- DROP_CNT_LEN, 16, drop counter width (only with MURE_DROP_CNT_EN)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  NRET  port retires an instruction
- iaddr_i  in  NRET×XLEN  instruction address
- itype_i  in  NRET×ITYPE_LEN  itype per port (0 std, 1 exc, 2 int, 3 ret, 4 nt-branch, 5 t-branch, 6/7 jumps)
- compressed_i  in  NRET  16-bit instruction
- priv_i  in  PRIV_LEN  current privilege, shared
- cause_i  in  CAUSE_LEN, tval_i  in  XLEN  trap info, shared
- ready_i  in  1  encoder accepts all valid lanes
- valid_o  out  N  lane holds a block
- iretire_o  out  N×IRETIRE_LEN; ilastsize_o  out  N; itype_o  out  N×ITYPE_LEN; cause_o  out  N×CAUSE_LEN; tval_o  out  N×XLEN; priv_o  out  N×PRIV_LEN; iaddr_o  out  N×XLEN
- overflow_o  out  1  sticky, a block was dropped
- dropped_o  out  DROP_CNT_LEN  drop count (macro only)

## Operation
- Ports are processed in index order each cycle; one open block is carried in registers across cycles.
- Port with itype 1/2 (valid ignored): contributes 0 halfwords and closes the open block with that itype. cause/tval are taken from cause_i/tval_i. Remaining ports that cycle are ignored.
- Port with valid=1, any other itype: adds 1 (compressed) or 2 halfwords to iretire and sets ilastsize = !compressed.
  - itype≠0: closes the block with that itype; cause/tval = 0.
  - itype 0: the block stays open unless iretire ≥ 2^IRETIRE_LEN−2 after adding, in which case it closes as itype 0 (saturation close).
- Port with valid=0 and itype∉{1,2}: no effect.
- Block iaddr and priv are latched from the first contributing port. An exception/interrupt on an empty block takes iaddr from its own port and priv from priv_i, with iretire=0 and ilastsize=0.
- Each port closes at most one block, so each cycle closes ≤ NRET blocks. Closed blocks are pushed in port order.
- Lanes 0..k−1 are valid, k = min(N, occupancy), oldest block on lane 0. Unused lanes drive all zeros.
- Handshake: when ready_i && valid_o[0], k blocks pop. Lane contents are stable while ready_i=0.
- Overflow: when closings exceed free slots (counting slots freed by the same-cycle pop), the blocks that fit are pushed in order and the rest are dropped. overflow_o is set and stays set until reset.

## Timing
- Block closed in cycle t is visible on valid_o at t+1 (registered store). No combinational path from commit inputs to outputs.
- Pop and push occur in the same cycle; a full store with simultaneous pop accepts up to the freed slots.
- ready_i→pop is same-edge; lanes update at t+1.
- Reset values: valid_o=0, all lane fields 0, overflow_o=0, dropped_o=0, open block empty (iretire 0).
- Reset mid-operation discards the open block and all stored blocks. The first cycle after deassertion behaves as after power-up.
- Occupancy pointers wrap modulo FIFO_DEPTH; the occupancy counter is $clog2(FIFO_DEPTH)+1 bits.

## Configuration
- MURE_DROP_CNT_EN defined: dropped_o counts dropped blocks, saturating at all-ones, reset to 0.
- Undefined: dropped_o port and counter are absent; only overflow_o reports loss.

## Structure
- mure_pkg holds:
  - block_s typedef (iretire, ilastsize, itype, cause, tval, priv, iaddr).
  - Itype code constants.
  - IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, PRIV_LEN, XLEN.
- Sub-module mure_block_fifo: circular store with NRET push ports and N pop ports, full/usage outputs, dtype = block_s.
- Top holds the open-block registers, per-port close logic, and overflow/drop tracking.

## Test plan
- NRET=2, one port valid=1 itype 0 (not compressed) per cycle for 3 cycles, then itype 5 (compressed) → one block at t+1: iretire=7, ilastsize=0, itype=5, iaddr = first pc.
- Port0 itype 4 and port1 itype 5 in the same cycle, N=2, ready_i=1 → next cycle valid_o=2'b11, lane0 itype 4, lane1 itype 5.
- Exception on port0 with empty block, cause=2, tval=0xDEAD → iretire=0, itype=1, cause=2, tval=0xDEAD; port1 ignored.
- Hold ready_i=0 while closing 17 blocks, FIFO_DEPTH=16 → 16 stored, overflow_o=1, dropped_o=1; lanes stable; after ready_i=1 all 16 drain in 8 cycles with N=2.
- IRETIRE_LEN=4, 7 uncompressed itype-0 instructions → saturation close with iretire=14, itype 0; the next instruction opens a new block.
- Assert rst_ni mid-stream with 5 blocks stored → all outputs 0 immediately; after release no stale block appears.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared types and widths for the E-trace block packer: the closed-block record and itype codes.
package mure_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;
    localparam int unsigned IRETIRE_LEN = 4;

    localparam logic [ITYPE_LEN-1:0] ITYPE_STD = 3'd0;
    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;
    localparam logic [ITYPE_LEN-1:0] ITYPE_RET = 3'd3;
    localparam logic [ITYPE_LEN-1:0] ITYPE_NTB = 3'd4;
    localparam logic [ITYPE_LEN-1:0] ITYPE_TB  = 3'd5;
    localparam logic [ITYPE_LEN-1:0] ITYPE_UJ  = 3'd6;
    localparam logic [ITYPE_LEN-1:0] ITYPE_IJ  = 3'd7;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } block_s;

endpackage

// File: rtl/mure_block_fifo.sv
// Circular block store with NPUSH write ports and NPOP read lanes; lane i shows the i-th oldest
// entry, zeros when not occupied.
module mure_block_fifo import mure_pkg::*; #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NPUSH = 2,
    parameter int unsigned NPOP  = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [CW-1:0]         push_cnt_i,
    input  block_s [NPUSH-1:0]    push_data_i,
    input  logic                  pop_i,
    output logic [CW-1:0]         pop_cnt_o,
    output logic [CW-1:0]         usage_o,
    output logic                  full_o,
    output logic [NPOP-1:0]       valid_o,
    output block_s [NPOP-1:0]     data_o
);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] usage_q;
    block_s        mem_q [DEPTH];

    // A pop drains every lane that currently holds a block.
    assign pop_cnt_o = pop_i ? ((usage_q > CW'(NPOP)) ? CW'(NPOP) : usage_q) : '0;
    assign usage_o   = usage_q;
    assign full_o    = (usage_q == CW'(DEPTH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
            rd_ptr_q <= rd_ptr_q + AW'(pop_cnt_o);
            usage_q  <= usage_q + push_cnt_i - pop_cnt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NPUSH; i++) begin
            if (CW'(i) < push_cnt_i) begin
                mem_q[wr_ptr_q + AW'(i)] <= push_data_i[i];
            end
        end
    end

    always_comb begin
        valid_o = '0;
        data_o  = '0;
        for (int i = 0; i < NPOP; i++) begin
            if (CW'(i) < usage_q) begin
                valid_o[i] = 1'b1;
                data_o[i]  = mem_q[rd_ptr_q + AW'(i)];
            end
        end
    end

endmodule

// File: rtl/mure_block_packer.sv
// Closes E-trace instruction blocks from NRET commit ports and presents them on N lanes.
// Define MURE_DROP_CNT_EN to add the saturating dropped_o counter.
module mure_block_packer import mure_pkg::*; #(
    parameter int unsigned NRET       = 2,
    parameter int unsigned N          = 2,
    parameter int unsigned FIFO_DEPTH = 16
`ifdef MURE_DROP_CNT_EN
    ,
    parameter int unsigned DROP_CNT_LEN = 16
`endif
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NRET-1:0]                  valid_i,
    input  logic [NRET-1:0][XLEN-1:0]        iaddr_i,
    input  logic [NRET-1:0][ITYPE_LEN-1:0]   itype_i,
    input  logic [NRET-1:0]                  compressed_i,
    input  logic [PRIV_LEN-1:0]              priv_i,
    input  logic [CAUSE_LEN-1:0]             cause_i,
    input  logic [XLEN-1:0]                  tval_i,
    input  logic                             ready_i,
    output logic [N-1:0]                     valid_o,
    output logic [N-1:0][IRETIRE_LEN-1:0]    iretire_o,
    output logic [N-1:0]                     ilastsize_o,
    output logic [N-1:0][ITYPE_LEN-1:0]      itype_o,
    output logic [N-1:0][CAUSE_LEN-1:0]      cause_o,
    output logic [N-1:0][XLEN-1:0]           tval_o,
    output logic [N-1:0][PRIV_LEN-1:0]       priv_o,
    output logic [N-1:0][XLEN-1:0]           iaddr_o,
    output logic                             overflow_o
`ifdef MURE_DROP_CNT_EN
    ,
    output logic [DROP_CNT_LEN-1:0]          dropped_o
`endif
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW  = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int unsigned SAT = 2 ** IRETIRE_LEN - 2;

    block_s              open_q, open_d;
    block_s [NRET-1:0]   close_blk;
    block_s [N-1:0]      lane;
    logic [CW-1:0]       close_cnt, push_cnt, free_cnt, drop_cnt, pop_cnt, usage;
    logic                full, overflow_q;

    // Walk ports in order; the open block only ever carries iretire/ilastsize/iaddr/priv.
    always_comb begin
        block_s blk;
        logic   stop;
        open_d    = open_q;
        close_blk = '0;
        close_cnt = '0;
        stop      = 1'b0;
        blk       = '0;
        for (int p = 0; p < NRET; p++) begin
            if (!stop) begin
                if (itype_i[p] == ITYPE_EXC || itype_i[p] == ITYPE_INT) begin
                    blk = open_d;
                    if (open_d.iretire == '0) begin
                        blk.iaddr = iaddr_i[p];
                        blk.priv  = priv_i;
                    end
                    blk.itype = itype_i[p];
                    blk.cause = cause_i;
                    blk.tval  = tval_i;
                    close_blk[PW'(close_cnt)] = blk;
                    close_cnt = close_cnt + CW'(1);
                    open_d    = '0;
                    stop      = 1'b1;
                end else if (valid_i[p]) begin
                    if (open_d.iretire == '0) begin
                        open_d.iaddr = iaddr_i[p];
                        open_d.priv  = priv_i;
                    end
                    open_d.iretire   = open_d.iretire +
                                       (compressed_i[p] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
                    open_d.ilastsize = ~compressed_i[p];
                    if (itype_i[p] != ITYPE_STD || 32'(open_d.iretire) >= SAT) begin
                        blk       = open_d;
                        blk.itype = itype_i[p];
                        close_blk[PW'(close_cnt)] = blk;
                        close_cnt = close_cnt + CW'(1);
                        open_d    = '0;
                    end
                end
            end
        end
    end

    // Slots freed by this cycle's pop are available to this cycle's pushes.
    assign free_cnt = (full ? '0 : (CW'(FIFO_DEPTH) - usage)) + pop_cnt;
    assign push_cnt = (close_cnt > free_cnt) ? free_cnt : close_cnt;
    assign drop_cnt = close_cnt - push_cnt;

    mure_block_fifo #(
        .DEPTH (FIFO_DEPTH),
        .NPUSH (NRET),
        .NPOP  (N)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_cnt_i  (push_cnt),
        .push_data_i (close_blk),
        .pop_i       (ready_i & valid_o[0]),
        .pop_cnt_o   (pop_cnt),
        .usage_o     (usage),
        .full_o      (full),
        .valid_o     (valid_o),
        .data_o      (lane)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            open_q     <= open_d;
            overflow_q <= overflow_q | (drop_cnt != '0);
        end
    end

    assign overflow_o = overflow_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            iretire_o[i]   = lane[i].iretire;
            ilastsize_o[i] = lane[i].ilastsize;
            itype_o[i]     = lane[i].itype;
            cause_o[i]     = lane[i].cause;
            tval_o[i]      = lane[i].tval;
            priv_o[i]      = lane[i].priv;
            iaddr_o[i]     = lane[i].iaddr;
        end
    end

`ifdef MURE_DROP_CNT_EN
    localparam int unsigned DW = DROP_CNT_LEN + 1;

    logic [DROP_CNT_LEN-1:0] dropped_q;
    logic [DROP_CNT_LEN:0]   drop_sum;

    assign drop_sum = {1'b0, dropped_q} + DW'(drop_cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= drop_sum[DROP_CNT_LEN] ? '1 : drop_sum[DROP_CNT_LEN-1:0];
        end
    end

    assign dropped_o = dropped_q;
`endif

endmodule

// File: tb/tb_mure_block_packer.sv
// Self-checking bench for mure_block_packer: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_mure_block_packer;
    import mure_pkg::*;

    localparam int unsigned NRET       = 2;
    localparam int unsigned N          = 2;
    localparam int unsigned FIFO_DEPTH = 16;
`ifdef MURE_DROP_CNT_EN
    localparam int unsigned DROP_CNT_LEN = 16;
`endif

    logic                             clk_i = 1'b0;
    logic                             rst_ni = 1'b0;
    logic [NRET-1:0]                  valid_i;
    logic [NRET-1:0][XLEN-1:0]        iaddr_i;
    logic [NRET-1:0][ITYPE_LEN-1:0]   itype_i;
    logic [NRET-1:0]                  compressed_i;
    logic [PRIV_LEN-1:0]              priv_i;
    logic [CAUSE_LEN-1:0]             cause_i;
    logic [XLEN-1:0]                  tval_i;
    logic                             ready_i;
    logic [N-1:0]                     valid_o;
    logic [N-1:0][IRETIRE_LEN-1:0]    iretire_o;
    logic [N-1:0]                     ilastsize_o;
    logic [N-1:0][ITYPE_LEN-1:0]      itype_o;
    logic [N-1:0][CAUSE_LEN-1:0]      cause_o;
    logic [N-1:0][XLEN-1:0]           tval_o;
    logic [N-1:0][PRIV_LEN-1:0]       priv_o;
    logic [N-1:0][XLEN-1:0]           iaddr_o;
    logic                             overflow_o;
`ifdef MURE_DROP_CNT_EN
    logic [DROP_CNT_LEN-1:0]          dropped_o;
`endif

    mure_block_packer #(
        .NRET       (NRET),
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
`ifdef MURE_DROP_CNT_EN
        ,
        .DROP_CNT_LEN (DROP_CNT_LEN)
`endif
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .iaddr_i      (iaddr_i),
        .itype_i      (itype_i),
        .compressed_i (compressed_i),
        .priv_i       (priv_i),
        .cause_i      (cause_i),
        .tval_i       (tval_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .iretire_o    (iretire_o),
        .ilastsize_o  (ilastsize_o),
        .itype_o      (itype_o),
        .cause_o      (cause_o),
        .tval_o       (tval_o),
        .priv_o       (priv_o),
        .iaddr_o      (iaddr_o),
        .overflow_o   (overflow_o)
`ifdef MURE_DROP_CNT_EN
        ,
        .dropped_o    (dropped_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: stored blocks in a queue, open block as plain counters.
    block_s             exp_q[$];
    int                 m_iret;
    logic               m_ils;
    logic [XLEN-1:0]    m_iaddr;
    logic [PRIV_LEN-1:0] m_priv;
    logic               m_ovf;
`ifdef MURE_DROP_CNT_EN
    longint             m_drops;
`endif

    function automatic void model_reset();
        exp_q.delete();
        m_iret  = 0;
        m_ils   = 1'b0;
        m_iaddr = '0;
        m_priv  = '0;
        m_ovf   = 1'b0;
`ifdef MURE_DROP_CNT_EN
        m_drops = 0;
`endif
    endfunction

    function automatic void model_cycle();
        block_s cl[$];
        block_s b;
        int     k;
        int     it;
        k = (exp_q.size() < N) ? exp_q.size() : N;
        if (ready_i && k > 0) begin
            repeat (k) void'(exp_q.pop_front());
        end
        for (int p = 0; p < NRET; p++) begin
            it = int'(itype_i[p]);
            if (it == 1 || it == 2) begin
                b = '0;
                if (m_iret == 0) begin
                    b.iaddr = iaddr_i[p];
                    b.priv  = priv_i;
                end else begin
                    b.iretire   = IRETIRE_LEN'(m_iret);
                    b.ilastsize = m_ils;
                    b.iaddr     = m_iaddr;
                    b.priv      = m_priv;
                end
                b.itype = itype_i[p];
                b.cause = cause_i;
                b.tval  = tval_i;
                cl.push_back(b);
                m_iret = 0;
                break;
            end else if (valid_i[p]) begin
                if (m_iret == 0) begin
                    m_iaddr = iaddr_i[p];
                    m_priv  = priv_i;
                end
                m_iret = m_iret + (compressed_i[p] ? 1 : 2);
                m_ils  = !compressed_i[p];
                if (it != 0 || m_iret >= (1 << IRETIRE_LEN) - 2) begin
                    b           = '0;
                    b.iretire   = IRETIRE_LEN'(m_iret);
                    b.ilastsize = m_ils;
                    b.itype     = itype_i[p];
                    b.iaddr     = m_iaddr;
                    b.priv      = m_priv;
                    cl.push_back(b);
                    m_iret = 0;
                end
            end
        end
        foreach (cl[j]) begin
            if (exp_q.size() < FIFO_DEPTH) begin
                exp_q.push_back(cl[j]);
            end else begin
                m_ovf = 1'b1;
`ifdef MURE_DROP_CNT_EN
                if (m_drops < (64'd1 << DROP_CNT_LEN) - 1) m_drops++;
`endif
            end
        end
    endfunction

    function automatic block_s lane(input int i);
        block_s b;
        b.iretire   = iretire_o[i];
        b.ilastsize = ilastsize_o[i];
        b.itype     = itype_o[i];
        b.cause     = cause_o[i];
        b.tval      = tval_o[i];
        b.priv      = priv_o[i];
        b.iaddr     = iaddr_o[i];
        return b;
    endfunction

    task automatic clear_inputs();
        valid_i      = '0;
        iaddr_i      = '0;
        itype_i      = '0;
        compressed_i = '0;
        priv_i       = '0;
        cause_i      = '0;
        tval_i       = '0;
    endtask

    // Advance one clock with the current inputs; outputs are sampled 1 unit after the edge.
    task automatic cycle();
        model_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        ready_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (valid_o !== '0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", valid_o);
        end
        checks++;
        if ({iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o} !== '0) begin
            failures++;
            $display("FAIL reset_lanes got=%h want=0", lane(0));
        end
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%b want=0", overflow_o);
        end
`ifdef MURE_DROP_CNT_EN
        checks++;
        if (dropped_o !== '0) begin
            failures++;
            $display("FAIL reset_dropped got=%0d want=0", dropped_o);
        end
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_single_block();
        clear_inputs();
        ready_i = 1'b0;
        priv_i  = 2'd1;
        for (int j = 0; j < 3; j++) begin
            valid_i[0] = 1'b1;
            iaddr_i[0] = 32'h8000_0000 + 32'(4 * j);
            cycle();
            checks++;
            if (valid_o !== 2'b00) begin
                failures++;
                $display("FAIL single_early got=%b want=00", valid_o);
            end
        end
        iaddr_i[0]      = 32'h8000_000c;
        itype_i[0]      = ITYPE_TB;
        compressed_i[0] = 1'b1;
        cycle();
        clear_inputs();
        checks++;
        if (valid_o !== 2'b01 || iretire_o[0] !== 4'd7 || ilastsize_o[0] !== 1'b0 ||
            itype_o[0] !== 3'd5 || iaddr_o[0] !== 32'h8000_0000 || priv_o[0] !== 2'd1) begin
            failures++;
            $display("FAIL single_block got v=%b blk=%h want v=01 iret=7 ils=0 it=5 ia=80000000",
                     valid_o, lane(0));
        end
        ready_i = 1'b1;
        cycle();
        checks++;
        if (valid_o !== 2'b00) begin
            failures++;
            $display("FAIL single_drain got=%b want=00", valid_o);
        end
    endtask

    task automatic test_two_close();
        clear_inputs();
        ready_i = 1'b1;
        valid_i = 2'b11;
        itype_i[0] = ITYPE_NTB;
        iaddr_i[0] = 32'h0000_1000;
        itype_i[1] = ITYPE_TB;
        iaddr_i[1] = 32'h0000_1004;
        compressed_i[1] = 1'b1;
        cycle();
        clear_inputs();
        checks++;
        if (valid_o !== 2'b11 || itype_o[0] !== 3'd4 || itype_o[1] !== 3'd5 ||
            iretire_o[0] !== 4'd2 || iretire_o[1] !== 4'd1 || iaddr_o[1] !== 32'h0000_1004) begin
            failures++;
            $display("FAIL two_close got v=%b l0=%h l1=%h want v=11 it=4/5 iret=2/1",
                     valid_o, lane(0), lane(1));
        end
        cycle();
        checks++;
        if (valid_o !== 2'b00) begin
            failures++;
            $display("FAIL two_close_pop got=%b want=00", valid_o);
        end
    endtask

    task automatic test_exception();
        clear_inputs();
        ready_i    = 1'b1;
        itype_i[0] = ITYPE_EXC;
        iaddr_i[0] = 32'h0000_4000;
        valid_i[1] = 1'b1;
        itype_i[1] = ITYPE_TB;
        iaddr_i[1] = 32'h0000_4004;
        cause_i    = 5'd2;
        tval_i     = 32'h0000_dead;
        priv_i     = 2'd3;
        cycle();
        clear_inputs();
        checks++;
        if (valid_o !== 2'b01 || iretire_o[0] !== 4'd0 || itype_o[0] !== 3'd1 ||
            cause_o[0] !== 5'd2 || tval_o[0] !== 32'h0000_dead || iaddr_o[0] !== 32'h0000_4000 ||
            priv_o[0] !== 2'd3 || ilastsize_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL exception got v=%b blk=%h want v=01 iret=0 it=1 cause=2 tval=dead",
                     valid_o, lane(0));
        end
        cycle();
        checks++;
        if (valid_o !== 2'b00) begin
            failures++;
            $display("FAIL exception_port1_ignored got=%b want=00", valid_o);
        end
    endtask

    task automatic test_overflow();
        block_s l0, l1;
        int     drains;
        clear_inputs();
        ready_i = 1'b0;
        l0 = '0;
        l1 = '0;
        for (int j = 0; j < 17; j++) begin
            valid_i[0] = 1'b1;
            itype_i[0] = ITYPE_NTB;
            iaddr_i[0] = 32'd100 + 32'(4 * j);
            cycle();
            if (j == 1) begin
                l0 = lane(0);
                l1 = lane(1);
            end
            if (j == 15) begin
                checks++;
                if (overflow_o !== 1'b0) begin
                    failures++;
                    $display("FAIL overflow_at_full got=%b want=0", overflow_o);
                end
            end
        end
        clear_inputs();
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set got=%b want=1", overflow_o);
        end
`ifdef MURE_DROP_CNT_EN
        checks++;
        if (dropped_o !== 16'd1) begin
            failures++;
            $display("FAIL overflow_dropped got=%0d want=1", dropped_o);
        end
`endif
        checks++;
        if (l0.iaddr !== 32'd100 || l1.iaddr !== 32'd104 || lane(0) !== l0 || lane(1) !== l1 ||
            valid_o !== 2'b11) begin
            failures++;
            $display("FAIL overflow_stable got l0=%h l1=%h want iaddr 100/104 unchanged",
                     lane(0), lane(1));
        end
        ready_i = 1'b1;
        drains  = 0;
        for (int j = 0; j < 20 && valid_o[0]; j++) begin
            checks++;
            if (valid_o !== 2'b11) begin
                failures++;
                $display("FAIL overflow_drain_lanes got=%b want=11", valid_o);
            end
            drains++;
            cycle();
        end
        checks++;
        if (drains != 8 || valid_o !== 2'b00) begin
            failures++;
            $display("FAIL overflow_drain_cycles got=%0d want=8", drains);
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        ready_i = 1'b1;
        for (int j = 0; j < 7; j++) begin
            valid_i[0] = 1'b1;
            iaddr_i[0] = 32'h0000_1000 + 32'(4 * j);
            cycle();
            if (j == 5) begin
                checks++;
                if (valid_o !== 2'b00) begin
                    failures++;
                    $display("FAIL sat_early got=%b want=00", valid_o);
                end
            end
        end
        valid_i[0] = 1'b1;
        itype_i[0] = ITYPE_TB;
        iaddr_i[0] = 32'h0000_2000;
        checks++;
        if (valid_o !== 2'b01 || iretire_o[0] !== 4'd14 || itype_o[0] !== 3'd0 ||
            ilastsize_o[0] !== 1'b1 || iaddr_o[0] !== 32'h0000_1000) begin
            failures++;
            $display("FAIL sat_close got v=%b blk=%h want iret=14 it=0 ils=1 ia=1000",
                     valid_o, lane(0));
        end
        cycle();
        clear_inputs();
        checks++;
        if (valid_o !== 2'b01 || iretire_o[0] !== 4'd2 || iaddr_o[0] !== 32'h0000_2000 ||
            itype_o[0] !== 3'd5) begin
            failures++;
            $display("FAIL sat_new_block got v=%b blk=%h want iret=2 ia=2000 it=5",
                     valid_o, lane(0));
        end
        cycle();
    endtask

    task automatic test_random();
        block_s e;
        int     r;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NRET; p++) begin
                valid_i[p]      = ($urandom_range(0, 3) != 0);
                compressed_i[p] = $urandom_range(0, 1) != 0;
                iaddr_i[p]      = $urandom();
                r = int'($urandom_range(0, 15));
                if (r < 8) itype_i[p] = ITYPE_STD;
                else if (r == 8) itype_i[p] = ITYPE_EXC;
                else if (r == 9) itype_i[p] = ITYPE_INT;
                else itype_i[p] = ITYPE_LEN'($urandom_range(3, 7));
            end
            priv_i  = PRIV_LEN'($urandom_range(0, 3));
            cause_i = CAUSE_LEN'($urandom_range(0, 31));
            tval_i  = $urandom();
            ready_i = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                e = '0;
                if (i < exp_q.size()) e = exp_q[i];
                checks++;
                if (valid_o[i] !== (i < exp_q.size())) begin
                    failures++;
                    $display("FAIL rand_valid c=%0d lane=%0d got=%b want=%b", c, i, valid_o[i],
                             (i < exp_q.size()));
                end
                checks++;
                if (lane(i) !== e) begin
                    failures++;
                    $display("FAIL rand_lane c=%0d lane=%0d got=%h want=%h", c, i, lane(i), e);
                end
            end
            checks++;
            if (overflow_o !== m_ovf) begin
                failures++;
                $display("FAIL rand_overflow c=%0d got=%b want=%b", c, overflow_o, m_ovf);
            end
`ifdef MURE_DROP_CNT_EN
            checks++;
            if (dropped_o !== DROP_CNT_LEN'(m_drops)) begin
                failures++;
                $display("FAIL rand_dropped c=%0d got=%0d want=%0d", c, dropped_o, m_drops);
            end
`endif
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        ready_i = 1'b1;
        repeat (12) cycle();
        // Flush any block left open by the random phase.
        itype_i[0] = ITYPE_EXC;
        cycle();
        clear_inputs();
        repeat (2) cycle();
        ready_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            valid_i[0] = 1'b1;
            itype_i[0] = ITYPE_NTB;
            iaddr_i[0] = 32'h0000_5000 + 32'(4 * j);
            cycle();
        end
        valid_i[0] = 1'b1;
        itype_i[0] = ITYPE_STD;
        iaddr_i[0] = 32'h0000_6000;
        cycle();
        clear_inputs();
        checks++;
        if (valid_o !== 2'b11 || exp_q.size() != 5) begin
            failures++;
            $display("FAIL mid_prefill got=%b want=11", valid_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== '0 || overflow_o !== 1'b0 ||
            {iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got v=%b ovf=%b l0=%h want all 0",
                     valid_o, overflow_o, lane(0));
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        valid_i[0]      = 1'b1;
        itype_i[0]      = ITYPE_TB;
        compressed_i[0] = 1'b1;
        iaddr_i[0]      = 32'h0000_3000;
        cycle();
        clear_inputs();
        checks++;
        if (valid_o !== 2'b01 || iretire_o[0] !== 4'd1 || iaddr_o[0] !== 32'h0000_3000) begin
            failures++;
            $display("FAIL mid_after_release got v=%b blk=%h want v=01 iret=1 ia=3000",
                     valid_o, lane(0));
        end
        cycle();
        checks++;
        if (valid_o !== 2'b01) begin
            failures++;
            $display("FAIL mid_no_stale got=%b want=01", valid_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_block();
        test_two_close();
        test_exception();
        test_overflow();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
